ex_mul_iter: RTL and testbench

Parametrised iterative multiplier for the second execute stage, running in parallel with the single-cycle ALU path. It accepts one operand pair per operation and carries the register-file writeback tag (RW, DA) alongside it. It produces a full double-width product after a multi-cycle shift-add sequence. It adds a signed/unsigned mode select, a busy/done handshake, pipeline-flush abort and reset.

---
 rtl/ex_mul_iter.sv | 127 ++++++++++++
 tb/tb_ex_mul_iter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: iterative shift-add multiplier for the second execute stage.
// Carries the writeback tag (RW, DA) alongside the operation and produces a
// 2*WIDTH product with a busy/done handshake, flush abort and async reset.
// Optional build macro: MUL_EARLY_OUT_EN ends the add phase as soon as the
// remaining multiplier bits are all zero.
module ex_mul_iter #(
    parameter int WIDTH = 32,
    parameter int DA_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 sgn,
    input  logic                 kill,
    input  logic                 RW,
    input  logic [DA_W-1:0]      DA,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done,
    output logic                 busy,
    output logic                 RW_out,
    output logic [DA_W-1:0]      DA_out
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2 * WIDTH)'(1);
    localparam logic [CW-1:0]      LAST   = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state, state_nx;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand_sh;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        cnt;
    logic                 neg;
    logic                 rw_l;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   acc_fixed;
    logic                 accept;
    logic                 calc_last;

    // Operand magnitudes, final sign fix-up and end-of-add-phase detection.
    always_comb begin
        mag_a     = (sgn && multiplicand[WIDTH-1]) ? (~multiplicand + ONE_W) : multiplicand;
        mag_b     = (sgn && multiplier[WIDTH-1])   ? (~multiplier + ONE_W)   : multiplier;
        acc_fixed = neg ? (~acc + ONE_2W) : acc;
`ifdef MUL_EARLY_OUT_EN
        calc_last = (cnt == LAST) || ((mplier >> 1) == '0);
`else
        calc_last = (cnt == LAST);
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and handshake outputs; kill forces IDLE but cannot retract
    // a done that is already being presented.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        done     = 1'b0;
        RW_out   = 1'b0;
        busy     = (state != IDLE);
        case (state)
            IDLE: begin
                if (go && !kill) begin
                    accept   = 1'b1;
                    state_nx = CALC;
                end
            end
            CALC: if (calc_last) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: begin
                done     = 1'b1;
                RW_out   = rw_l;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (kill) state_nx = IDLE;
    end

    // Datapath: latch at accept, shift-add in CALC, sign fix in FIX.
    // product is loaded only from FIX so an aborted run never disturbs it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            mcand_sh <= '0;
            mplier   <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            rw_l     <= 1'b0;
            product  <= '0;
            DA_out   <= '0;
        end else if (accept) begin
            acc      <= '0;
            mcand_sh <= {{WIDTH{1'b0}}, mag_a};
            mplier   <= mag_b;
            cnt      <= '0;
            neg      <= sgn & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            rw_l     <= RW;
            DA_out   <= DA;
        end else if (!kill) begin
            case (state)
                CALC: begin
                    if (mplier[0]) acc <= acc + mcand_sh;
                    mcand_sh <= mcand_sh << 1;
                    mplier   <= mplier >> 1;
                    cnt      <= cnt + 1'b1;
                end
                FIX: begin
                    acc     <= acc_fixed;
                    product <= acc_fixed;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mul_iter.sv
// Self-checking bench for ex_mul_iter: directed cases plus random operand
// pairs compared against a plain-arithmetic reference.
module tb_ex_mul_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0, sgn = 1'b0, kill = 1'b0, RW = 1'b0;
    logic [4:0]  DA = '0;
    logic [31:0] multiplicand = '0, multiplier = '0;
    logic [63:0] product;
    logic        done, busy, RW_out;
    logic [4:0]  DA_out;

    int tests = 0;
    int fails = 0;
    logic [63:0] last_p  = '0;
    logic [4:0]  last_da = '0;

    ex_mul_iter #(.WIDTH(32), .DA_W(5)) dut (
        .clk(clk), .rst(rst), .go(go), .sgn(sgn), .kill(kill), .RW(RW), .DA(DA),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .product(product), .done(done), .busy(busy), .RW_out(RW_out), .DA_out(DA_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit s);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Cycles from accept edge to the cycle in which done is seen.
    function automatic int exp_lat(input logic [31:0] b, input bit s);
`ifdef MUL_EARLY_OUT_EN
        logic [31:0] m;
        int n;
        m = (s && b[31]) ? (~b + 32'd1) : b;
        n = 1;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
        return n + 2;
`else
        return 34;
`endif
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s, input bit rw,
                          input logic [4:0] da, input bit hold, input bit kd, output logic [63:0] p);
        logic [63:0] exp_p;
        int lat, n;
        bit seen;
        exp_p = ref_mul(a, b, s);
        lat   = exp_lat(b, s);
        @(negedge clk);
        go = 1'b1; sgn = s; RW = rw; DA = da; multiplicand = a; multiplier = b;
        @(posedge clk);
        n = 0; seen = 1'b0; p = '0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (done) begin
                seen = 1'b1;
                p    = product;
                go   = 1'b0;
                check("latency", 64'(n), 64'(lat));
                check("product", product, exp_p);
                check("rw_out_done", {63'b0, RW_out}, {63'b0, rw});
                check("da_out_done", {59'b0, DA_out}, {59'b0, da});
                if (kd) begin
                    kill = 1'b1;
                    #1 check("done_under_kill", {63'b0, done}, 64'd1);
                end
            end else begin
                if (n == 1) check("busy_after_accept", {63'b0, busy}, 64'd1);
                if (hold) begin
                    multiplicand = $urandom; multiplier = $urandom;
                    sgn = ~sgn; RW = ~RW; DA = DA + 5'd1;
                end else begin
                    go = 1'b0;
                end
            end
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
        kill = 1'b0;
        check("done_pulse_len", {63'b0, done}, 64'd0);
        check("busy_after_done", {63'b0, busy}, 64'd0);
        check("rw_out_idle", {63'b0, RW_out}, 64'd0);
        check("da_out_held", {59'b0, DA_out}, {59'b0, da});
        last_p  = exp_p;
        last_da = da;
    endtask

    initial begin
        logic [63:0] p;
        logic [31:0] ra, rb;
        int ndone;

        #2;
        check("rst_product", product, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_rw_out", {63'b0, RW_out}, 64'd0);
        check("rst_da_out", {59'b0, DA_out}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        run_op(32'd7, 32'hFFFFFFFD, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, p);
        check("signed_7x-3", p, 64'hFFFFFFFF_FFFFFFEB);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, p);
        check("unsigned_max", p, 64'hFFFFFFFE_00000001);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, p);
        check("signed_m1xm1", p, 64'h00000000_00000001);
        run_op(32'h80000000, 32'h80000000, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, p);
        check("most_neg_sq", p, 64'h40000000_00000000);
        run_op(32'h80000000, 32'd1, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0, p);
        check("most_neg_x1", p, 64'hFFFFFFFF_80000000);
        run_op(32'd5, 32'd3, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, p);
        check("5x3", p, 64'd15);
        run_op(32'h12345678, 32'd0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, p);
        check("x0", p, 64'd0);

        // go held high while busy with changing operands and tags
        run_op(32'd1000, 32'd77, 1'b0, 1'b1, 5'd21, 1'b1, 1'b0, p);
        check("hold_first_ops", p, 64'd77000);

        // kill arriving during the done cycle
        run_op(32'hFFFFFFF6, 32'd12, 1'b1, 1'b1, 5'd11, 1'b0, 1'b1, p);

        // kill together with go in IDLE: nothing accepted
        @(negedge clk);
        go = 1'b1; kill = 1'b1; multiplicand = 32'd9; multiplier = 32'd9; DA = 5'd30;
        @(negedge clk);
        go = 1'b0; kill = 1'b0;
        check("kill_go_busy", {63'b0, busy}, 64'd0);
        check("kill_go_da", {59'b0, DA_out}, {59'b0, last_da});

        // kill during CALC cycle 10
        @(negedge clk);
        go = 1'b1; sgn = 1'b0; RW = 1'b1; DA = 5'd17;
        multiplicand = 32'hFFFFFFFF; multiplier = 32'hFFFFFFFF;
        @(negedge clk);
        go = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy", {63'b0, busy}, 64'd0);
        check("kill_done", {63'b0, done}, 64'd0);
        check("kill_rw_out", {63'b0, RW_out}, 64'd0);
        check("kill_product_held", product, last_p);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || RW_out) ndone++;
        end
        check("kill_no_late_done", 64'(ndone), 64'd0);

        // asynchronous reset mid-CALC
        @(negedge clk);
        go = 1'b1; sgn = 1'b1; RW = 1'b1; DA = 5'd13;
        multiplicand = 32'd123; multiplier = 32'hFFFF0000;
        @(negedge clk);
        go = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_product", product, 64'd0);
        check("arst_busy", {63'b0, busy}, 64'd0);
        check("arst_done", {63'b0, done}, 64'd0);
        check("arst_rw_out", {63'b0, RW_out}, 64'd0);
        check("arst_da_out", {59'b0, DA_out}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // random operands, sign mode and tags
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 5))
                0:       ra = 32'h80000000;
                1:       ra = 32'hFFFFFFFF;
                2:       ra = $urandom_range(0, 15);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'h80000000;
                1:       rb = 32'd0;
                2:       rb = $urandom_range(0, 300);
                default: rb = $urandom;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0, p);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
